// File: rtl/strobe_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// strobe_arbiter_pkg : shared constants and helpers for strobe_arbiter
// Rev 1.0
// ============================================================================
package strobe_arbiter_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 8;
  localparam int MAX_CH     = 64;
  localparam int MAX_CH_W   = 6;

  function automatic int ch_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // First set bit of req searched upward from ptr, wrapping at nch.
  function automatic logic rr_select(input logic [MAX_CH-1:0] req, input int nch,
                                     input int ptr, output int idx);
    logic found;
    int   c;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < MAX_CH; k++) begin
      c = ptr + k;
      if (c >= nch) c = c - nch;
      if (!found && (k < nch) && req[c[MAX_CH_W-1:0]]) begin
        found = 1'b1;
        idx   = c;
      end
    end
    return found;
  endfunction

endpackage
`default_nettype wire

// File: rtl/strobe_arbiter_edge.sv
`default_nettype none
// ============================================================================
// edge_strober : one-cycle strobe on a rising edge of a synchronous level
// Rev 1.0
// ============================================================================
module edge_strober (
  input  logic clk,
  input  logic resetn,
  input  logic sig_i,
  output logic strobe_o
);

  logic prev_q;
  logic strobe_q;

  // prev_q resets low so a level already high at reset release yields a strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      prev_q   <= sig_i;
      strobe_q <= sig_i & ~prev_q;
    end
  end

  assign strobe_o = strobe_q;

endmodule
`default_nettype wire

// File: rtl/strobe_arbiter.sv
`default_nettype none
// ============================================================================
// strobe_arbiter : per-channel edge events served round-robin through a
//                  valid/ready output register, with a saturating drop count
// Rev 1.0
// ============================================================================
module strobe_arbiter
  import strobe_arbiter_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] signal,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [CH_W-1:0]   event_ch,
  output logic [NUM_CH-1:0] pending,
  output logic [CNT_W-1:0]  drop_count,
  input  logic              drop_clr
);

  logic [NUM_CH-1:0] strobe, req, grant_oh, drop_vec;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic              valid_q, valid_d, load, found;
  logic [CH_W-1:0]   ch_q, ch_d, rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  int                grant_idx;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_strobe
      edge_strober u_edge (
        .clk      (clk),
        .resetn   (resetn),
        .sig_i    (signal[gi]),
        .strobe_o (strobe[gi])
      );
    end
  endgenerate

  assign req  = pending_q | strobe;
  assign load = ~valid_q | event_ready;

  always_comb begin
    grant_idx = 0;
    found     = rr_select(MAX_CH'(req), NUM_CH, int'(rr_ptr_q), grant_idx);
    grant_oh  = '0;
    valid_d   = valid_q;
    ch_d      = ch_q;
    rr_ptr_d  = rr_ptr_q;
    if (load) begin
      valid_d = found;
      if (found) begin
        for (int i = 0; i < NUM_CH; i++) grant_oh[i] = (grant_idx == i);
        ch_d     = CH_W'(grant_idx);
        rr_ptr_d = (grant_idx == NUM_CH - 1) ? '0 : CH_W'(grant_idx + 1);
      end
    end

    // A granted channel with a fresh strobe keeps pending: the new edge replaces the served one.
    drop_vec  = strobe & pending_q & ~grant_oh;
    pending_d = (pending_q | strobe) & ~(grant_oh & ~(strobe & pending_q));

    drop_d = drop_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (drop_vec[i] && (drop_d != '1)) drop_d = drop_d + CNT_W'(1);
    end
    if (drop_clr) drop_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= 1'b0;
      ch_q      <= '0;
      rr_ptr_q  <= '0;
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      ch_q      <= ch_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  assign event_valid = valid_q;
  assign event_ch    = ch_q;
  assign pending     = pending_q;
  assign drop_count  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_strobe_arbiter.sv
`default_nettype none
// ============================================================================
// tb_strobe_arbiter : scoreboard bench with an event-count reference model
// Rev 1.0
// ============================================================================
module tb_strobe_arbiter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] signal = 4'b0;
  logic       event_ready = 1'b0;
  logic       drop_clr = 1'b0;

  logic       event_valid, event_valid2;
  logic [1:0] event_ch, event_ch2;
  logic [3:0] pending, pending2;
  logic [7:0] drop_count;
  logic [1:0] drop_count2;

  strobe_arbiter #(.NUM_CH(4), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .signal(signal), .event_valid(event_valid),
    .event_ready(event_ready), .event_ch(event_ch), .pending(pending),
    .drop_count(drop_count), .drop_clr(drop_clr)
  );

  strobe_arbiter #(.NUM_CH(4), .CNT_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .signal(signal), .event_valid(event_valid2),
    .event_ready(event_ready), .event_ch(event_ch2), .pending(pending2),
    .drop_count(drop_count2), .drop_clr(drop_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per channel, a count of captured-but-unserved events
  // (at most one survives), fed by edges that arrive one cycle after sampling.
  int  m_arr[4]  = '{0, 0, 0, 0};
  int  m_wait[4] = '{0, 0, 0, 0};
  int  m_prev[4] = '{0, 0, 0, 0};
  bit  m_valid   = 1'b0;
  int  m_ch      = 0;
  int  m_ptr     = 0;
  int  m_drop    = 0;
  int  m_drop2   = 0;
  int  exp_q[$];

  function automatic logic [3:0] m_pend();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (m_wait[i] != 0);
    return v;
  endfunction

  always @(posedge clk or negedge resetn) begin
    int g, nd, tot, c;
    bit ld;
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        m_arr[i] = 0; m_wait[i] = 0; m_prev[i] = 0;
      end
      m_valid = 1'b0; m_ch = 0; m_ptr = 0; m_drop = 0; m_drop2 = 0;
      exp_q.delete();
    end else begin
      ld = !m_valid || event_ready;
      g  = -1;
      if (ld) begin
        for (int k = 0; k < 4; k++) begin
          c = (m_ptr + k) % 4;
          if (g < 0 && (m_wait[c] + m_arr[c]) > 0) g = c;
        end
      end
      nd = 0;
      for (int i = 0; i < 4; i++) begin
        tot = m_wait[i] + m_arr[i];
        if (i == g) tot = tot - 1;
        if (tot > 1) begin nd++; tot = 1; end
        m_wait[i] = tot;
      end
      if (drop_clr) begin
        m_drop = 0; m_drop2 = 0;
      end else begin
        m_drop  = (m_drop + nd > 255) ? 255 : m_drop + nd;
        m_drop2 = (m_drop2 + nd > 3) ? 3 : m_drop2 + nd;
      end
      if (ld) begin
        if (g >= 0) begin
          m_valid = 1'b1; m_ch = g; m_ptr = (g + 1) % 4;
          exp_q.push_back(g);
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        m_arr[i]  = (signal[i] && m_prev[i] == 0) ? 1 : 0;
        m_prev[i] = signal[i] ? 1 : 0;
      end
    end
  end

  // Monitor: per-cycle state compare plus scoreboard pop on each handshake.
  always @(negedge clk) begin
    int e;
    chk("event_valid", event_valid, m_valid);
    if (m_valid) chk("event_ch", event_ch, m_ch);
    chk("pending", pending, m_pend());
    chk("drop_count", drop_count, m_drop);
    chk("drop_count_w2", drop_count2, m_drop2);
    if (resetn && event_valid && event_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got event ch %0d expected none at %0t", event_ch, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_ch", event_ch, e);
        n_xfer++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    step(3);
    chk("reset_valid", event_valid, 0);
    chk("reset_pending", pending, 0);
    chk("reset_drop", drop_count, 0);
    resetn = 1'b1;
    step(1);

    // single event on ch2
    event_ready = 1'b1;
    signal = 4'b0100; step(4);
    signal = 4'b0000; step(2);

    // simultaneous edges on 0, 1, 3
    signal = 4'b1011; step(6);
    signal = 4'b0000; step(2);

    // fairness: ch0/ch1 toggled in phase every 2 cycles
    for (int i = 0; i < 8; i++) begin
      signal[1:0] = ~signal[1:0];
      step(2);
    end
    signal = 4'b0000; step(3);

    // backpressure on ch1
    event_ready = 1'b0;
    signal = 4'b0010; step(3);
    signal = 4'b0000; step(1);
    signal = 4'b0010; step(2);
    signal = 4'b0000; step(1);
    signal = 4'b0010; step(2);
    event_ready = 1'b1;
    signal = 4'b0000; step(6);

    // drive the drop counters into saturation, then clear alongside drops
    event_ready = 1'b0;
    for (int i = 0; i < 200; i++) begin
      signal = ~signal;
      step(1);
    end
    drop_clr = 1'b1; signal = ~signal; step(1);
    drop_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      signal = ~signal;
      step(1);
    end
    event_ready = 1'b1;
    signal = 4'b0000; step(10);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      signal      = 4'($urandom);
      event_ready = ($urandom_range(0, 3) != 0);
      drop_clr    = ($urandom_range(0, 31) == 0);
      step(1);
    end
    drop_clr = 1'b0;
    signal   = 4'b0000; event_ready = 1'b1; step(6);

    // reset while an event is presented and ch1/ch3 are pending
    event_ready = 1'b0;
    signal = 4'b0001; step(2);
    signal = 4'b1011; step(2);
    chk("pre_reset_pending", pending, 4'b1010);
    resetn = 1'b0;
    #1;
    chk("async_valid", event_valid, 0);
    chk("async_ch", event_ch, 0);
    chk("async_pending", pending, 0);
    chk("async_drop", drop_count, 0);
    signal = 4'b1000;
    @(posedge clk);
    @(posedge clk);
    #5;
    resetn = 1'b1;
    event_ready = 1'b1;
    step(6);

    // drain and confirm nothing is left outstanding
    signal = 4'b0000; step(10);
    chk("sb_drained", exp_q.size(), 0);
    chk("drain_valid", event_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/strobe_arbiter.md
# strobe_arbiter

Multi-channel event scheduler for level inputs. Each of NUM_CH level signals gets its own rising-edge strobe generator. Each edge is captured as a pending event, and events are served to one downstream consumer through a round-robin arbiter and a valid/ready output register. Each edge produces exactly one handshaken event carrying its channel index. Lost edges are counted.

## Interface
- NUM_CH, 4: number of input channels, ≥2.
- CNT_W, 8: width of the saturating drop counter.
- CH_W, derived: max(1, clog2(NUM_CH)). Not overridable.

- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset; clears all state immediately.
- signal  in  NUM_CH  level inputs, synchronous to clk.
- event_valid  out  1  an event is presented.
- event_ready  in  1  consumer accepts the event.
- event_ch  out  CH_W  channel index of the presented event.
- pending  out  NUM_CH  captured events not yet loaded into the output register.
- drop_count  out  CNT_W  count of lost edges; saturates at all-ones.
- drop_clr  in  1  synchronous clear of drop_count.

## Operation
- **Edge strobe.** Per channel, strobe[i] is high for exactly one cycle after the first clock edge at which signal[i] is sampled high following a low sample. The prior-sample register resets to 0, so a signal already high at reset release produces one strobe.
- **Request vector.** req = pending | strobe.
- **Load.** load = ~event_valid | event_ready.
  - load and req ≠ 0: event_valid←1, event_ch←grant, rr_ptr←(grant+1) mod NUM_CH.
  - load and req = 0: event_valid←0.
  - no load: event_valid and event_ch hold, bit-stable.
- **Round robin.** grant is the first set req bit searched upward from rr_ptr, wrapping. rr_ptr resets to 0.
- **Pending update, per channel i** (g = granted channel this cycle):
  - granted, no strobe: clear.
  - granted, strobe and pending both set: stays set (new event replaces the served one); no drop.
  - not granted, strobe, pending clear: set.
  - not granted, strobe, pending already set: stays set; drop event.
- **drop_count.** Increments by 1 per drop event; multiple drops in one cycle add their popcount. Saturates at all-ones. drop_clr has priority: count←0 and same-cycle drops are discarded.
- **Reset.** Async assertion, effective mid-transfer: event_valid=0, event_ch=0, pending=0, drop_count=0, rr_ptr=0, strobe registers=0.

## Timing
- Latency: signal[i] rise sampled at edge E0 → strobe[i] high after E0 → event_valid=1, event_ch=i after E1, when the output register is free or being handshaken at E1.
- Throughput: one event per cycle while event_ready=1.
- Handshake: transfer occurs at an edge where event_valid & event_ready. The next event is loaded at that same edge (no bubble).
- strobe cannot assert on consecutive cycles for a channel, so each channel carries at most one pending plus one in-flight event.

## Structure
- Shared package strobe_arbiter_pkg:
  - CH_W derivation function (clog2 with minimum 1).
  - Default NUM_CH/CNT_W constants.
  - Round-robin priority-select function (req, ptr → grant index, found flag).
- Sub-module edge_strober: 1-bit rising-edge strobe with async active-low reset. Instantiated NUM_CH times via generate.

## Test plan
All scenarios use NUM_CH=4, CNT_W=8 unless stated.

1. **Single event.** signal[2] 0→1, sampled at E0, event_ready=1 → event_valid=1, event_ch=2 after E1; event_valid=0 after E2; pending stays 0.
2. **Simultaneous edges.** Channels 0, 1, 3 rise together, rr_ptr=0, event_ready=1 → event_ch 0, 1, 3 on three consecutive cycles; event_valid high for exactly 3 cycles; rr_ptr ends at 0.
3. **Round-robin fairness.**
   - Setup: hold event_ready=1.
   - Stimulus: toggle signal[0] and signal[1] every 2 cycles, in phase.
   - Required: grants alternate 0, 1, 0, 1.
   - Required: no channel granted twice while the other is pending.
4. **Backpressure.**
   - Stimulus: event_ready=0; ch1 rises → event_ch=1 held stable.
   - Stimulus: ch1 falls and rises again → pending=4'b0010.
   - Stimulus: ch1 falls and rises a third time → drop_count=1.
   - Stimulus: raise event_ready.
   - Required: two ch1 transfers follow, then event_valid=0.
5. **Saturation and clear.**
   - Setup: CNT_W=2.
   - Stimulus: force 5 drops → drop_count=3.
   - Stimulus: drop_clr coincident with a drop → drop_count=0.
6. **Reset mid-operation.**
   - Setup: event_valid=1, pending=4'b1010.
   - Stimulus: resetn low mid-cycle → all outputs 0 before the next edge.
   - Stimulus: release resetn with signal[3] held high → one event on ch3 (E0 = first edge after release).
